chip8_draw_engine: RTL
======================

// Module: chip8_draw_engine
// PURPOSE
//  Sequencer for the CHIP-8 DXYN draw instruction. On start, it reads N sprite bytes from RAM at I
//  and read-modify-writes the matching 64-bit framebuffer rows with XOR.
//  Sits between the CPU core and the RAM/framebuffer ports; the core stalls while busy=1.
//  Reports the collision flag, which the core writes to VF.
// PARAMETERS
//  DISP_W  64  framebuffer width in pixels (row word width)
//  DISP_H  32  framebuffer height in rows
//  ADDR_W  12  RAM address width
// PORTS
//  instruction_clk  in   1       clock; all state changes on its rising edge
//  rst_n            in   1       reset: asynchronous, active-low
//  start            in   1       request a draw; sampled only in IDLE
//  vx               in   8       X coordinate (VX), latched on accepted start
//  vy               in   8       Y coordinate (VY), latched on accepted start
//  n                in   4       sprite height in rows, latched on accepted start
//  i_addr           in   ADDR_W  sprite base address (I), latched on accepted start
//  busy             out  1       high from the cycle after an accepted start through the DONE cycle
//  done             out  1       one-cycle pulse when the draw completes
//  collision        out  1       valid while done=1; 1 = at least one lit pixel was erased
//  mem_rd_en        out  1       RAM read strobe
//  mem_addr         out  ADDR_W  RAM read address
//  mem_rd_data      in   8       RAM data, valid the cycle after mem_rd_en
//  fb_row_addr      out  5       framebuffer row index (read and write)
//  fb_rd_data       in   DISP_W  row data, valid the cycle after FETCH; bit x = pixel x
//  fb_wr_en         out  1       framebuffer row write strobe
//  fb_wr_data       out  DISP_W  row data to write
// BEHAVIOUR
//  - Reset values (rst_n=0, asynchronous):
//    - state=IDLE.
//    - busy, done, collision, mem_rd_en, fb_wr_en = 0.
//    - mem_addr, fb_row_addr, fb_wr_data = 0.
//    - Row counter and collision accumulator = 0.
//  - Reset mid-draw: abort immediately. Rows already written stay written. No done pulse is produced.
//  - Latching on start: x0=vx%64 and y0=vy%32 (low bits), plus n and i_addr. Row counter r=0.
//  - start while busy: ignored. A start held high in the DONE cycle is not accepted; it is seen again in IDLE.
//  - States:
//    - IDLE: on start, go to FETCH, or to DONE if n=0.
//    - FETCH: mem_rd_en=1, mem_addr=(i_addr+r) mod 2^ADDR_W, fb_row_addr=y0+r. Next state WAIT.
//    - WAIT: register mem_rd_data into spr and fb_rd_data into row. Next state WRITE.
//    - WRITE: fb_wr_en=1, fb_row_addr held, fb_wr_data = row ^ mask.
//      - Accumulate collision |= |(row & mask).
//      - r++. If r==n or the next row is clipped, go to DONE; else go to FETCH.
//    - DONE: done=1, collision output valid. Clear the accumulator on exit. Next state IDLE.
//  - Mask: spr bit 7-b maps to pixel x0+b, for b=0..7 (MSB is leftmost).
//  - Clipping (default):
//    - Pixels with x0+b >= 64 are dropped from the mask.
//    - A row is clipped when y0+r >= 32; drawing terminates at the first clipped row.
//    - The first row is never clipped.
//  - A write always occurs for each drawn row, even when spr=0. That write leaves the row unchanged.
//  - Latency: done is high exactly 3*R+1 cycles after the start-sampling edge, where R = rows drawn.
//    For n=0, R=0 and done is high 1 cycle after that edge.
//  - busy=1 in the FETCH, WAIT, WRITE and DONE states. mem_rd_en and fb_wr_en are never high in the same cycle.
// CONFIGURATION
//  - Macro CHIP8_DRAW_WRAP_EN:
//    - Defined: pixel x = (x0+b) mod 64 and row = (y0+r) mod 32. No clipping; exactly n rows are always drawn.
//    - Undefined: clipping as described under BEHAVIOUR.
// TESTING
//  1. Font draw: vx=0, vy=0, n=5, i_addr=80, RAM[80..84]=F0 90 90 90 F0, framebuffer all zero.
//     -> Five writes to rows 0..4. Row 0 data=0x000000000000000F, row 1 data=0x9 (bits 0,3).
//     -> done at cycle 16, collision=0.
//  2. Repeat test 1 without clearing the framebuffer.
//     -> Rows 0..4 are written back to 0, collision=1.
//  3. vx=62, vy=0, n=1, sprite byte FF.
//     -> Clip build: only bits 62 and 63 set.
//     -> CHIP8_DRAW_WRAP_EN build: bits 62, 63 and 0..5 set.
//  4. vy=30, n=4.
//     -> Clip build: rows 30 and 31 written, done at cycle 7.
//     -> WRAP build: rows 30, 31, 0, 1 written, done at cycle 13.
//  5. vx=70, vy=40, n=0.
//     -> No mem_rd_en, no fb_wr_en, done at cycle 1, collision=0.
//     -> vx=70 with n=1 (sprite byte 80) draws at x=6, y=8.
//  6. Assert rst_n=0 in the WAIT state of row 2 of an n=5 draw.
//     -> All outputs 0 in the same cycle, no done pulse.
//     -> After release, a fresh start completes normally with the correct latency.
//     -> Also: start pulsed while busy is ignored, with no second done pulse.

Source files
------------

// File: rtl/chip8_draw_engine.sv
// rtl/chip8_draw_engine.sv - CHIP-8 DXYN sprite draw sequencer; optional macro CHIP8_DRAW_WRAP_EN selects wrap instead of clip
module chip8_draw_engine #(
    parameter int DISP_W = 64,
    parameter int DISP_H = 32,
    parameter int ADDR_W = 12
) (
    input  logic                       instruction_clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 vx,
    input  logic [7:0]                 vy,
    input  logic [3:0]                 n,
    input  logic [ADDR_W-1:0]          i_addr,
    output logic                       busy,
    output logic                       done,
    output logic                       collision,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [7:0]                 mem_rd_data,
    output logic [$clog2(DISP_H)-1:0]  fb_row_addr,
    input  logic [DISP_W-1:0]          fb_rd_data,
    output logic                       fb_wr_en,
    output logic [DISP_W-1:0]          fb_wr_data
);

    localparam int XW  = $clog2(DISP_W);
    localparam int YW  = $clog2(DISP_H);
    localparam int YPW = YW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [XW-1:0]       x0;
    logic [YW-1:0]       y0;
    logic [3:0]          n_q;
    logic [ADDR_W-1:0]   base;
    logic [3:0]          r;
    logic [7:0]          spr;
    logic [DISP_W-1:0]   row;
    logic                acc;
    logic [4:0]          r_next;
    logic [YW-1:0]       cur_row;
    logic [7:0]          spr_rev;
    logic [DISP_W-1:0]   mask;
    logic                last_row;
    logic                unused_coord_bits;

    // Coordinates are taken modulo the display size, so the high bits are intentionally ignored
    assign unused_coord_bits = ^{vx[7:XW], vy[7:YW]};

    assign r_next  = {1'b0, r} + 5'd1;
    assign cur_row = y0 + YW'(r);
    // Sprite MSB is the leftmost pixel, so bit-reverse it before shifting into place
    assign spr_rev = {spr[0], spr[1], spr[2], spr[3], spr[4], spr[5], spr[6], spr[7]};

`ifdef CHIP8_DRAW_WRAP_EN
    logic [2*DISP_W-1:0] wide;
    // Pixels shifted past the right edge fold back onto the left edge
    assign wide     = {{DISP_W{1'b0}}, DISP_W'(spr_rev)} << x0;
    assign mask     = wide[DISP_W-1:0] | wide[2*DISP_W-1:DISP_W];
    assign last_row = (r_next == {1'b0, n_q});
`else
    logic [YPW-1:0] y_next;
    // Pixels shifted past the right edge fall off; drawing stops at the bottom edge
    assign mask     = DISP_W'(spr_rev) << x0;
    assign y_next   = {1'b0, y0} + YPW'(r_next);
    assign last_row = (r_next == {1'b0, n_q}) || (y_next >= YPW'(DISP_H));
`endif

    // State register plus operand latches, row/sprite capture and collision accumulator
    always_ff @(posedge instruction_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            x0    <= '0;
            y0    <= '0;
            n_q   <= '0;
            base  <= '0;
            r     <= '0;
            spr   <= '0;
            row   <= '0;
            acc   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x0   <= vx[XW-1:0];
                        y0   <= vy[YW-1:0];
                        n_q  <= n;
                        base <= i_addr;
                        r    <= '0;
                    end
                end
                S_WAIT: begin
                    spr <= mem_rd_data;
                    row <= fb_rd_data;
                end
                S_WRITE: begin
                    acc <= acc | (|(row & mask));
                    r   <= r + 4'd1;
                end
                S_DONE: acc <= 1'b0;
                default: ;
            endcase
        end
    end

    // Next-state and output decode; every output is zero in IDLE so reset clears them at once
    always_comb begin
        state_nx    = state;
        busy        = 1'b0;
        done        = 1'b0;
        collision   = 1'b0;
        mem_rd_en   = 1'b0;
        mem_addr    = '0;
        fb_row_addr = '0;
        fb_wr_en    = 1'b0;
        fb_wr_data  = '0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = (n == 4'd0) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                busy        = 1'b1;
                mem_rd_en   = 1'b1;
                mem_addr    = base + ADDR_W'(r);
                fb_row_addr = cur_row;
                state_nx    = S_WAIT;
            end
            S_WAIT: begin
                busy        = 1'b1;
                fb_row_addr = cur_row;
                state_nx    = S_WRITE;
            end
            S_WRITE: begin
                busy        = 1'b1;
                fb_row_addr = cur_row;
                fb_wr_en    = 1'b1;
                fb_wr_data  = row ^ mask;
                state_nx    = last_row ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                collision = acc;
                state_nx  = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule
